// File: rtl/threadbrain_pkg.sv
// Shared definitions for the register-file fetch arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package threadbrain_pkg;

  // Stride and field positions of one packed register-file entry.
  localparam int ENTRY_W = 35;
  localparam int VALID_B = 34;
  localparam int RETR_B  = 33;
  localparam int LOCK_B  = 32;
  localparam int TAG_LSB = 16;
  localparam int VAL_LSB = 0;
  localparam int TAG_W   = 16;
  localparam int VAL_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WB   = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/rf_rr_pick.sv
// Round-robin picker: first set bit of elig scanning upward from rr_ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
// Ports: elig (eligibility vector), rr_ptr (scan start) -> any (a bit was found), idx (its index).
module rf_rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  elig,
  input  logic [PW-1:0] rr_ptr,
  output logic          any,
  output logic [PW-1:0] idx
);

  int cand;

  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= N) cand = cand - N;
      if (!any && elig[cand]) begin
        any = 1'b1;
        idx = PW'(cand);
      end
    end
  end

endmodule

// File: rtl/rf_fetch_arb.sv
// Arbitrates register-file entries waiting on a memory read onto one shared read port.
// Latency: grant edge -> mem_req next cycle; ack -> wb_en next cycle; WB -> IDLE one cycle.
// Backpressure: REQ holds mem_req/mem_addr until mem_ack; one read outstanding at a time.
// Ports: clk, rst_n; rf_in (packed entries); mem_req/mem_addr/mem_ack/mem_rdata (shared read port);
//        wb_en/wb_num/wb_val (write-back strobe to the register file); busy (FSM not idle).
module rf_fetch_arb #(
  parameter int NCORES  = 4,
  parameter int ENTRY_W = 35,
  localparam int IW     = $clog2(NCORES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NCORES*ENTRY_W-1:0] rf_in,
  output logic                      mem_req,
  output logic [15:0]               mem_addr,
  input  logic                      mem_ack,
  input  logic [15:0]               mem_rdata,
  output logic                      wb_en,
  output logic [IW-1:0]             wb_num,
  output logic [15:0]               wb_val,
  output logic                      busy
);

  import threadbrain_pkg::*;

  fetch_state_e state_q, state_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]    grant_q, grant_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [VAL_W-1:0] data_q, data_d;

  logic [NCORES-1:0] elig;
  logic              pick_any;
  logic [IW-1:0]     pick_idx;
  logic [TAG_W-1:0]  pick_tag;
  logic              grant_live;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NCORES; i++) begin
      elig[i] = rf_in[i*ENTRY_W + VALID_B] & rf_in[i*ENTRY_W + RETR_B]
              & ~rf_in[i*ENTRY_W + LOCK_B];
    end
  end

  rf_rr_pick #(
    .N  (NCORES),
    .PW (IW)
  ) u_pick (
    .elig   (elig),
    .rr_ptr (rr_ptr_q),
    .any    (pick_any),
    .idx    (pick_idx)
  );

  always_comb begin
    pick_tag   = rf_in[int'(pick_idx)*ENTRY_W + TAG_LSB +: TAG_W];
    // Lock state is deliberately ignored here: a lock taken after the grant
    // must not drop data the entry is still waiting for.
    grant_live = rf_in[int'(grant_q)*ENTRY_W + VALID_B]
               & rf_in[int'(grant_q)*ENTRY_W + RETR_B];
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    tag_d    = tag_q;
    data_d   = data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          tag_d   = pick_tag;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          data_d  = mem_rdata;
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        rr_ptr_d = (grant_q == IW'(NCORES-1)) ? '0 : grant_q + 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      tag_q    <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      tag_q    <= tag_d;
      data_q   <= data_d;
    end
  end

  // Request side depends on flops only, so rf_in never reaches the memory port.
  assign mem_req  = (state_q == ST_REQ);
  assign mem_addr = tag_q;
  assign wb_en    = (state_q == ST_WB) & grant_live;
  assign wb_num   = grant_q;
  assign wb_val   = data_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rf_fetch_arb.sv
module tb_rf_fetch_arb;

  logic         clk;
  logic         rst_n;
  logic [139:0] rf_in;
  logic         mem_req;
  logic [15:0]  mem_addr;
  logic         mem_ack;
  logic [15:0]  mem_rdata;
  logic         wb_en;
  logic [1:0]   wb_num;
  logic [15:0]  wb_val;
  logic         busy;

  int n_cmp  = 0;
  int n_fail = 0;

  rf_fetch_arb #(.NCORES(4), .ENTRY_W(35)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rf_in     (rf_in),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .wb_en     (wb_en),
    .wb_num    (wb_num),
    .wb_val    (wb_val),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [34:0] ent(input logic v, input logic r, input logic l,
                                      input logic [15:0] tag);
    return {v, r, l, tag, 16'h0000};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    logic stable_ok;
    rst_n     = 1'b0;
    rf_in     = '0;
    mem_ack   = 1'b0;
    mem_rdata = 16'h0;
    #1;
    chk("rst_mem_req",  32'(mem_req),  0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_wb_en",    32'(wb_en),    0);
    chk("rst_wb_num",   32'(wb_num),   0);
    chk("rst_wb_val",   32'(wb_val),   0);
    chk("rst_busy",     32'(busy),     0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Single fetch of entry 2, ack one cycle after mem_req rises.
    rf_in[2*35 +: 35] = ent(1, 1, 0, 16'h1234);
    tick();
    chk("single_req",  32'(mem_req),  1);
    chk("single_addr", 32'(mem_addr), 32'h1234);
    chk("single_busy", 32'(busy),     1);
    tick();
    chk("single_req_hold", 32'(mem_req), 1);
    mem_ack   = 1'b1;
    mem_rdata = 16'hBEEF;
    tick();
    mem_ack = 1'b0;
    #1;
    chk("single_wb_en",  32'(wb_en),   1);
    chk("single_wb_num", 32'(wb_num),  2);
    chk("single_wb_val", 32'(wb_val),  32'hBEEF);
    chk("single_req_wb", 32'(mem_req), 0);
    rf_in = '0;
    tick();
    chk("single_wb_en_off", 32'(wb_en),          0);
    chk("single_idle",      32'(busy),           0);
    chk("single_rr_ptr",    32'(dut.rr_ptr_q),   3);

    // Fairness: all entries eligible, immediate ack; rotation from 0 with wrap.
    do_reset();
    for (int i = 0; i < 4; i++) rf_in[i*35 +: 35] = ent(1, 1, 0, 16'hA000 + 16'(i));
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("fair_req",  32'(mem_req),  1);
      chk("fair_addr", 32'(mem_addr), 32'hA000 + 32'(k % 4));
      mem_ack   = 1'b1;
      mem_rdata = 16'h0C00 + 16'(k);
      tick();
      mem_ack = 1'b0;
      #1;
      chk("fair_wb_num", 32'(wb_num), 32'(k % 4));
      chk("fair_wb_en",  32'(wb_en),  1);
      chk("fair_wb_val", 32'(wb_val), 32'h0C00 + 32'(k));
      tick();
    end
    chk("fair_rr_ptr", 32'(dut.rr_ptr_q), 1);

    // Locked skip: entry 0 locked, entry 1 eligible.
    rf_in = '0;
    do_reset();
    rf_in[0*35 +: 35] = ent(1, 1, 1, 16'h0010);
    rf_in[1*35 +: 35] = ent(1, 1, 0, 16'h0011);
    tick();
    chk("lock_addr", 32'(mem_addr), 32'h0011);
    mem_ack   = 1'b1;
    mem_rdata = 16'h1111;
    tick();
    mem_ack = 1'b0;
    #1;
    chk("lock_wb_num", 32'(wb_num), 1);
    rf_in[1*35 +: 35] = ent(1, 0, 0, 16'h0011);
    tick();
    tick();
    tick();
    chk("lock_no_grant", 32'(busy), 0);
    rf_in[0*35 +: 35] = ent(1, 1, 0, 16'h0010);
    tick();
    chk("unlock_req",  32'(mem_req),  1);
    chk("unlock_addr", 32'(mem_addr), 32'h0010);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    rf_in = '0;
    tick();
    chk("unlock_rr_ptr", 32'(dut.rr_ptr_q), 1);

    // Stall: ack withheld 10 cycles while tags churn.
    rf_in[1*35 +: 35] = ent(1, 1, 0, 16'h5555);
    tick();
    stable_ok = (mem_req === 1'b1) && (mem_addr === 16'h5555) && (busy === 1'b1);
    for (int c = 1; c <= 10; c++) begin
      rf_in[1*35 +: 35] = ent(1, 1, 0, 16'($urandom));
      rf_in[2*35 +: 35] = ent(1, 1, 0, 16'($urandom));
      tick();
      if (!((mem_req === 1'b1) && (mem_addr === 16'h5555) && (busy === 1'b1)))
        stable_ok = 1'b0;
    end
    chk("stall_stable_11", 32'(stable_ok), 1);
    chk("stall_addr_end",  32'(mem_addr),  32'h5555);
    rf_in[2*35 +: 35] = '0;
    mem_ack   = 1'b1;
    mem_rdata = 16'h7777;
    tick();
    mem_ack = 1'b0;
    #1;
    chk("stall_wb_en",  32'(wb_en),  1);
    chk("stall_wb_num", 32'(wb_num), 1);
    chk("stall_wb_val", 32'(wb_val), 32'h7777);
    rf_in = '0;
    tick();
    chk("stall_rr_ptr", 32'(dut.rr_ptr_q), 2);

    // Stale write-back: entry 1 invalidated during REQ.
    rf_in[1*35 +: 35] = ent(1, 1, 0, 16'h0101);
    tick();
    chk("stale_req", 32'(mem_req), 1);
    rf_in[1*35 +: 35] = ent(0, 1, 0, 16'h0101);
    mem_ack   = 1'b1;
    mem_rdata = 16'hDEAD;
    tick();
    mem_ack = 1'b0;
    #1;
    chk("stale_wb_en", 32'(wb_en), 0);
    chk("stale_busy",  32'(busy),  1);
    tick();
    chk("stale_idle",    32'(busy),          0);
    chk("stale_rr_ptr",  32'(dut.rr_ptr_q),  2);

    // Reset mid-REQ, then a stray ack.
    rf_in = '0;
    rf_in[3*35 +: 35] = ent(1, 1, 0, 16'h0333);
    tick();
    chk("rreq_req", 32'(mem_req), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rreq_req_drop", 32'(mem_req), 0);
    chk("rreq_busy",     32'(busy),    0);
    rf_in = '0;
    tick();
    rst_n     = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 16'hF00D;
    tick();
    chk("rreq_stray_wb", 32'(wb_en), 0);
    chk("rreq_stray_busy", 32'(busy), 0);
    mem_ack = 1'b0;
    tick();
    chk("rreq_stray_wb2", 32'(wb_en), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
